// File: rtl/aes_wb_initiator.sv
// rtl/aes_wb_initiator.sv - Wishbone classic master that runs one AES-192 job on a Wishbone AES slave
module aes_wb_initiator #(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter logic [AW-1:0] BASE_ADDR   = '0,
  parameter int            POLL_GAP    = 4,
  parameter int            ACK_TIMEOUT = 255,
  parameter int            POLL_LIMIT  = 1023
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [127:0]  job_pt,
  input  logic [191:0]  job_key,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [127:0]  res_ct,
  output logic          res_err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  // Slave word map
  localparam logic [3:0] IDX_GO   = 4'd0;
  localparam logic [3:0] IDX_PT0  = 4'd1;
  localparam logic [3:0] IDX_PT3  = 4'd4;
  localparam logic [3:0] IDX_KEY0 = 4'd5;
  localparam logic [3:0] IDX_KEY5 = 4'd10;
  localparam logic [3:0] IDX_STAT = 4'd11;
  localparam logic [3:0] IDX_CT0  = 4'd12;
  localparam logic [3:0] IDX_CT3  = 4'd15;

  // The gap after the start write is never shorter than one cycle, so a
  // stale valid bit cannot be sampled in the same cycle as the start edge.
  // Between polls the gap is exactly POLL_GAP (zero means back-to-back polls).
  localparam int             GAP_LEN   = (POLL_GAP < 1) ? 1 : POLL_GAP;
  localparam int             GW        = $clog2(GAP_LEN + 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_LEN - 1);
  localparam int             PW        = $clog2(POLL_LIMIT + 2);
  localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_LIMIT);
  localparam logic [7:0]     TO_LAST   = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_KEY,
    S_WR_PT,
    S_WR_GO,
    S_GAP,
    S_POLL,
    S_RD_CT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [7:0]      to_q, to_d;
  logic [127:0]    pt_q;
  logic [191:0]    key_q;
  logic [127:0]    ct_q;
  logic            err_q;

  logic            bus_active;
  logic            bus_write;
  logic            xfer_ack;
  logic            xfer_err;
  logic            timeout;
  logic            accept;
  logic            abort;
  logic            ct_shift;
  logic [DW-1:0]   wdata;

  assign bus_active = (state_q == S_WR_KEY) || (state_q == S_WR_PT) ||
                      (state_q == S_WR_GO)  || (state_q == S_POLL)  ||
                      (state_q == S_RD_CT);
  assign bus_write  = (state_q == S_WR_KEY) || (state_q == S_WR_PT) ||
                      (state_q == S_WR_GO);

  // An error response beats an acknowledge seen in the same cycle.
  assign xfer_err = bus_active && wb_err_i;
  assign xfer_ack = bus_active && wb_ack_i && !wb_err_i;
  assign timeout  = bus_active && !wb_ack_i && !wb_err_i && (to_q == TO_LAST);

  // State and per-transfer/per-job counters
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      to_q    <= to_d;
    end
  end

  // Next-state: walk the word map, poll status, collect ciphertext, abort on error
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    poll_d   = poll_q;
    to_d     = '0;
    accept   = 1'b0;
    abort    = 1'b0;
    ct_shift = 1'b0;

    if (bus_active && !wb_ack_i && !wb_err_i) begin
      to_d = to_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          accept  = 1'b1;
          state_d = S_WR_KEY;
          idx_d   = IDX_KEY0;
          poll_d  = '0;
        end
      end
      S_WR_KEY: begin
        if (xfer_ack) begin
          if (idx_q == IDX_KEY5) begin
            state_d = S_WR_PT;
            idx_d   = IDX_PT0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_WR_PT: begin
        if (xfer_ack) begin
          if (idx_q == IDX_PT3) begin
            state_d = S_WR_GO;
            idx_d   = IDX_GO;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_WR_GO: begin
        if (xfer_ack) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_POLL;
          idx_d   = IDX_STAT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_POLL: begin
        if (xfer_ack) begin
          if (wb_dat_i[0]) begin
            state_d = S_RD_CT;
            idx_d   = IDX_CT0;
          end else if (poll_q == POLL_LAST) begin
            abort = 1'b1;
          end else begin
            poll_d = poll_q + PW'(1);
            if (POLL_GAP != 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end
      end
      S_RD_CT: begin
        if (xfer_ack) begin
          ct_shift = 1'b1;
          if (idx_q == IDX_CT3) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (xfer_err || timeout) begin
      abort = 1'b1;
    end
    if (abort) begin
      state_d  = S_DONE;
      ct_shift = 1'b0;
    end
  end

  // Job operands, ciphertext assembly (MSW first) and error flag
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pt_q  <= '0;
      key_q <= '0;
      ct_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        pt_q  <= job_pt;
        key_q <= job_key;
        ct_q  <= '0;
        err_q <= 1'b0;
      end else if (abort) begin
        ct_q  <= '0;
        err_q <= 1'b1;
      end else if (ct_shift) begin
        ct_q <= {ct_q[127-DW:0], wb_dat_i};
      end
    end
  end

  // Write data for the word currently addressed
  always_comb begin
    wdata = '0;
    case (idx_q)
      4'd0:    wdata = DW'(1);
      4'd1:    wdata = pt_q[31:0];
      4'd2:    wdata = pt_q[63:32];
      4'd3:    wdata = pt_q[95:64];
      4'd4:    wdata = pt_q[127:96];
      4'd5:    wdata = key_q[31:0];
      4'd6:    wdata = key_q[63:32];
      4'd7:    wdata = key_q[95:64];
      4'd8:    wdata = key_q[127:96];
      4'd9:    wdata = key_q[159:128];
      4'd10:   wdata = key_q[191:160];
      default: wdata = '0;
    endcase
  end

  // Bus signals follow registered state only, so they hold until ack/err
  // and drop at once on reset.
  assign wb_cyc_o  = bus_active;
  assign wb_stb_o  = bus_active;
  assign wb_we_o   = bus_write;
  assign wb_sel_o  = 4'hF;
  assign wb_adr_o  = bus_active ? (BASE_ADDR + AW'(idx_q)) : '0;
  assign wb_dat_o  = bus_write ? wdata : '0;

  assign job_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_ct    = ct_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_aes_wb_initiator.sv
// tb/tb_aes_wb_initiator.sv - directed self-checking bench for aes_wb_initiator
module tb_aes_wb_initiator;

  localparam int PG        = 4;
  localparam int FG        = (PG < 1) ? 1 : PG;
  localparam int EXP_LAT   = 11 + FG + 1 + 4 + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         job_valid;
  logic         job_ready;
  logic [127:0] job_pt;
  logic [191:0] job_key;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_ct;
  logic         res_err;
  logic [31:0]  wb_adr_o;
  logic [31:0]  wb_dat_o;
  logic [31:0]  wb_dat_i;
  logic [3:0]   wb_sel_o;
  logic         wb_we_o;
  logic         wb_cyc_o;
  logic         wb_stb_o;
  logic         wb_ack_i;
  logic         wb_err_i;

  logic [127:0] ct_model  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  logic [127:0] pt_model  = 128'h00112233445566778899aabbccddeeff;
  logic [191:0] key_model = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

  int errors = 0;
  int checks = 0;

  // slave configuration
  int          wait_states = 0;
  int          valid_delay = 0;
  bit          never_valid = 0;
  logic [31:0] stall_adr   = 32'hFFFF_FFFF;
  logic [31:0] err_adr     = 32'hFFFF_FFFF;

  // slave state
  int   ws_cnt;
  int   vcnt;
  bit   armed;
  logic st_valid;

  // monitor state
  int          stb_cycles, stall_cycles, polls, sel_bad, hold_bad, hold_seen;
  int          idle_run, ngaps, gmin, gmax;
  bit          prev_pend;
  logic [31:0] p_adr, p_dat;
  logic        p_we;
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];

  aes_wb_initiator #(.POLL_GAP(PG)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_pt   (job_pt),
    .job_key  (job_key),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_ct   (res_ct),
    .res_err  (res_err),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  always #5 clk = ~clk;

  assign wb_ack_i = wb_cyc_o && wb_stb_o && (ws_cnt == wait_states) && (wb_adr_o != stall_adr);
  assign wb_err_i = wb_cyc_o && wb_stb_o && (wb_adr_o == err_adr);
  assign st_valid = armed && (vcnt == 0) && !never_valid;

  always_comb begin
    wb_dat_i = 32'd0;
    case (wb_adr_o)
      32'd11:  wb_dat_i = {31'd0, st_valid};
      32'd12:  wb_dat_i = ct_model[127:96];
      32'd13:  wb_dat_i = ct_model[95:64];
      32'd14:  wb_dat_i = ct_model[63:32];
      32'd15:  wb_dat_i = ct_model[31:0];
      default: wb_dat_i = 32'd0;
    endcase
  end

  // slave model: wait states and delayed valid after the start write
  always @(posedge clk) begin
    if (!rst_n) begin
      ws_cnt <= 0;
      vcnt   <= 0;
      armed  <= 1'b0;
    end else begin
      if (wb_stb_o && !wb_ack_i && !wb_err_i) ws_cnt <= ws_cnt + 1;
      else ws_cnt <= 0;
      if (wb_stb_o && wb_we_o && wb_ack_i && !wb_err_i && wb_adr_o == 32'd0 && wb_dat_o == 32'd1) begin
        armed <= 1'b1;
        vcnt  <= valid_delay;
      end else if (armed && vcnt > 0) begin
        vcnt <= vcnt - 1;
      end
    end
  end

  // bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        hold_seen++;
        if (!(wb_cyc_o && wb_stb_o && wb_adr_o == p_adr && wb_we_o == p_we && wb_dat_o == p_dat))
          hold_bad++;
      end
      prev_pend = wb_stb_o && !wb_ack_i && !wb_err_i;
      p_adr = wb_adr_o;
      p_dat = wb_dat_o;
      p_we  = wb_we_o;
      if (wb_stb_o && wb_sel_o != 4'hF) sel_bad++;
      if (wb_stb_o) stb_cycles++;
      if (wb_stb_o && wb_adr_o == stall_adr) stall_cycles++;
      if (wb_stb_o && wb_we_o && wb_ack_i && !wb_err_i) begin
        wr_adr.push_back(wb_adr_o);
        wr_dat.push_back(wb_dat_o);
      end
      if (wb_stb_o && !wb_we_o && wb_ack_i && !wb_err_i && wb_adr_o == 32'd11) polls++;
      if (!wb_cyc_o) begin
        idle_run++;
      end else begin
        if (wb_adr_o == 32'd11 && idle_run > 0) begin
          ngaps++;
          if (idle_run < gmin) gmin = idle_run;
          if (idle_run > gmax) gmax = idle_run;
        end
        idle_run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    stb_cycles = 0; stall_cycles = 0; polls = 0; sel_bad = 0;
    hold_bad = 0; hold_seen = 0; idle_run = 0; ngaps = 0;
    gmin = 100000; gmax = 0;
    wr_adr.delete();
    wr_dat.delete();
  endtask

  task automatic start_job(input string tag);
    check({tag, "_job_ready"}, job_ready, 1'b1);
    job_pt    = pt_model;
    job_key   = key_model;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input int limit, output int n);
    n = 1;
    while (!res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 1'b0);
    check({tag, "_ready_back"}, job_ready, 1'b1);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] ea, ed;
    rst_n = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
    job_pt = '0; job_key = '0;
    clear_stats();
    prev_pend = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cyc_in_reset", wb_cyc_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_ct", res_ct, 128'd0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);

    // FIPS-197 vector, zero-wait slave, valid on first poll
    clear_stats();
    start_job("t1");
    wait_res(200, n);
    check("t1_res_valid", res_valid, 1'b1);
    check("t1_latency", n, EXP_LAT);
    check("t1_ct", res_ct, ct_model);
    check("t1_err", res_err, 1'b0);
    check("t1_nwrites", wr_adr.size(), 11);
    check("t1_sel", sel_bad, 0);
    check("t1_polls", polls, 1);
    for (int i = 0; i < 11; i++) begin
      if (i < 6) begin
        ea = 32'(5 + i);
        ed = key_model[32*i +: 32];
      end else if (i < 10) begin
        ea = 32'(i - 5);
        ed = pt_model[32*(i-6) +: 32];
      end else begin
        ea = 32'd0;
        ed = 32'd1;
      end
      check($sformatf("t1_wr_adr%0d", i), (i < wr_adr.size()) ? wr_adr[i] : 32'hx, ea);
      check($sformatf("t1_wr_dat%0d", i), (i < wr_dat.size()) ? wr_dat[i] : 32'hx, ed);
    end
    // result held while res_ready is low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t1_hold_valid%0d", i), res_valid, 1'b1);
      check($sformatf("t1_hold_ct%0d", i), res_ct, ct_model);
    end
    consume("t1");

    // 3 wait states, valid 40 cycles after start
    wait_states = 3; valid_delay = 40;
    clear_stats();
    start_job("t2");
    wait_res(1000, n);
    check("t2_res_valid", res_valid, 1'b1);
    check("t2_ct", res_ct, ct_model);
    check("t2_err", res_err, 1'b0);
    check("t2_hold_bad", hold_bad, 0);
    check("t2_hold_seen", hold_seen > 0, 1'b1);
    check("t2_sel", sel_bad, 0);
    check("t2_gap_min", gmin, PG);
    check("t2_gap_max", gmax, PG);
    check("t2_multi_poll", ngaps >= 2, 1'b1);
    consume("t2");

    // error response (with simultaneous ack) on the idx 7 key write
    wait_states = 0; valid_delay = 0; err_adr = 32'd7;
    clear_stats();
    start_job("t3");
    wait_res(200, n);
    check("t3_res_valid", res_valid, 1'b1);
    check("t3_err", res_err, 1'b1);
    check("t3_ct", res_ct, 128'd0);
    check("t3_nwrites", wr_adr.size(), 2);
    repeat (5) @(negedge clk);
    check("t3_stb_cycles", stb_cycles, 3);
    check("t3_still_valid", res_valid, 1'b1);
    consume("t3");
    err_adr = 32'hFFFF_FFFF;

    // slave never acks idx 8
    stall_adr = 32'd8;
    clear_stats();
    start_job("t4");
    wait_res(600, n);
    check("t4_res_valid", res_valid, 1'b1);
    check("t4_err", res_err, 1'b1);
    check("t4_ct", res_ct, 128'd0);
    check("t4_stall_cycles", stall_cycles, 255);
    consume("t4");
    stall_adr = 32'hFFFF_FFFF;

    // status never valid
    never_valid = 1'b1;
    clear_stats();
    start_job("t5");
    wait_res(8000, n);
    check("t5_res_valid", res_valid, 1'b1);
    check("t5_err", res_err, 1'b1);
    check("t5_polls", polls, 1024);
    consume("t5");
    never_valid = 1'b0;

    // asynchronous reset in the middle of the plaintext writes
    wait_states = 3;
    clear_stats();
    start_job("t6");
    n = 0;
    while (!(wb_stb_o && wb_adr_o == 32'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_pt", wb_stb_o && wb_adr_o == 32'd2, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_cyc_drop", wb_cyc_o, 1'b0);
    check("t6_stb_drop", wb_stb_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_job_ready", job_ready, 1'b1);
    check("t6_cyc_idle", wb_cyc_o, 1'b0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || wb_cyc_o) seen = 1'b1;
    end
    check("t6_no_result", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
